// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store sequencer for an async-read, word-wide data memory.
// Optional LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of masking the low address bits.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_fault,
    output logic [15:0] mem_addr,
    output logic        mem_write_en,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        READ  = 4'b0010,
        WRITE = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    state_t      state_reg, state_next;
    logic        store_reg, signed_reg, fault_reg, mem_write_en_reg;
    logic [1:0]  size_reg, lane_reg;
    logic [15:0] wdata_reg, mem_addr_reg;
    logic [31:0] mem_write_data_reg, resp_data_reg;

    logic        accept, is_word_req, is_half_req, misaligned, fault_in;
    logic [1:0]  lane_in;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_result, merged;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:18];

    assign accept      = req_valid && req_ready;
    assign is_word_req = req_size[1];
    assign is_half_req = (req_size == 2'b01);
    assign misaligned  = (is_half_req && req_addr[0]) || (is_word_req && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
    assign fault_in = misaligned;
    assign lane_in  = req_addr[1:0];
`else
    assign fault_in = 1'b0;
    // Misaligned accesses are silently rounded down to their natural alignment.
    assign lane_in  = is_word_req ? 2'b00 : (is_half_req ? {req_addr[1], 1'b0} : req_addr[1:0]);
`endif

    always_comb begin
        byte_val = mem_read_data[{lane_reg, 3'b000} +: 8];
        half_val = lane_reg[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        if (size_reg[1])
            load_result = mem_read_data;
        else if (size_reg[0])
            load_result = {{16{signed_reg & half_val[15]}}, half_val};
        else
            load_result = {{24{signed_reg & byte_val[7]}}, byte_val};

        merged = mem_read_data;
        if (size_reg[0])
            merged[{lane_reg[1], 4'b0000} +: 16] = wdata_reg;
        else
            merged[{lane_reg, 3'b000} +: 8] = wdata_reg[7:0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (fault_in)
                        state_next = DONE;
                    else if (req_store && is_word_req)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = store_reg ? WRITE : DONE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            store_reg          <= 1'b0;
            signed_reg         <= 1'b0;
            size_reg           <= 2'b00;
            lane_reg           <= 2'b00;
            wdata_reg          <= 16'h0;
            fault_reg          <= 1'b0;
            mem_addr_reg       <= 16'h0;
            mem_write_en_reg   <= 1'b0;
            mem_write_data_reg <= 32'h0;
            resp_data_reg      <= 32'h0;
        end else begin
            state_reg        <= state_next;
            // Strobe is a flop so the memory sees a clean, glitch-free single-cycle pulse.
            mem_write_en_reg <= (state_next == WRITE);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        store_reg    <= req_store;
                        signed_reg   <= req_signed;
                        size_reg     <= req_size;
                        lane_reg     <= lane_in;
                        wdata_reg    <= req_wdata[15:0];
                        fault_reg    <= fault_in;
                        mem_addr_reg <= req_addr[17:2];
                        if (req_store && is_word_req && !fault_in)
                            mem_write_data_reg <= req_wdata;
                    end
                end
                READ: begin
                    if (store_reg)
                        mem_write_data_reg <= merged;
                    else
                        resp_data_reg <= load_result;
                end
                default: ;
            endcase
        end
    end

    assign req_ready      = (state_reg == IDLE) && rst_n;
    assign resp_valid     = (state_reg == DONE);
    assign resp_fault     = fault_reg;
    assign resp_data      = resp_data_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_write_en   = mem_write_en_reg;
    assign mem_write_data = mem_write_data_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide async-read memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_store = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_fault, mem_write_en;
    logic [31:0] resp_data, mem_write_data, mem_read_data;
    logic [15:0] mem_addr;

    logic [31:0] mem [0:65535];
    int checks = 0;
    int fails  = 0;
    logic [31:0] last_load = 32'h0;

    // Results of the most recent drive_req call
    int          lat, wpulses, wat;
    logic [31:0] rdata, wdat;
    logic [15:0] waddr;
    logic        rfault;

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_addr];
    always @(posedge clk) if (mem_write_en) mem[mem_addr] <= mem_write_data;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_fault(resp_fault), .mem_addr(mem_addr),
        .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    // Issues one request, scrambles req_* right after accept, and records response timing.
    task automatic drive_req(input logic st, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd);
        lat = 0; wpulses = 0; wat = 0; rdata = 32'hx; rfault = 1'bx; waddr = 16'hx; wdat = 32'hx;
        @(negedge clk);
        req_store = st; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_signed = 1'($urandom); req_store = 1'($urandom);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_write_en) begin
                wpulses++; wat = i; waddr = mem_addr; wdat = mem_write_data;
            end
            if (resp_valid) begin
                lat = i; rdata = resp_data; rfault = resp_fault;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (mem_write_en !== 1'b0) begin fails++; $display("FAIL reset_wen: got %b expected 0", mem_write_en); end
        checks++; if (resp_fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b expected 0", resp_fault); end
        checks++; if ({resp_data, mem_write_data, mem_addr} !== 80'h0) begin fails++; $display("FAIL reset_regs: got %h %h %h expected zeros", resp_data, mem_write_data, mem_addr); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_word;
        drive_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++; if (lat !== 2) begin fails++; $display("FAIL word_store_lat: got %0d expected 2", lat); end
        checks++; if (wpulses !== 1 || wat !== 1) begin fails++; $display("FAIL word_store_wen: got pulses %0d at %0d expected 1 at 1", wpulses, wat); end
        checks++; if (waddr !== 16'd4) begin fails++; $display("FAIL word_store_addr: got %h expected 0004", waddr); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL word_store_mem: got %h expected deadbeef", mem[4]); end
        drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++; if (lat !== 2 || rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL word_load: got lat %0d data %h expected 2 deadbeef", lat, rdata); end
        checks++; if (wpulses !== 0) begin fails++; $display("FAIL word_load_wen: got %0d expected 0", wpulses); end
        last_load = 32'hDEADBEEF;
    endtask

    task automatic test_subword_load;
        drive_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        checks++; if (rdata !== 32'hFFFFFFDE) begin fails++; $display("FAIL lb_signed: got %h expected ffffffde", rdata); end
        drive_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        checks++; if (rdata !== 32'h000000DE) begin fails++; $display("FAIL lb_unsigned: got %h expected 000000de", rdata); end
        drive_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        checks++; if (rdata !== 32'h000000EF) begin fails++; $display("FAIL lb_lane0: got %h expected 000000ef", rdata); end
        drive_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        checks++; if (rdata !== 32'hFFFFBEEF) begin fails++; $display("FAIL lh_signed: got %h expected ffffbeef", rdata); end
        drive_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        checks++; if (rdata !== 32'h0000DEAD || lat !== 2) begin fails++; $display("FAIL lh_upper: got %h lat %0d expected 0000dead lat 2", rdata, lat); end
        last_load = 32'h0000DEAD;
    endtask

    task automatic test_subword_store;
        drive_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00AB1234);
        checks++; if (lat !== 3) begin fails++; $display("FAIL sh_lat: got %0d expected 3", lat); end
        checks++; if (wpulses !== 1 || wat !== 2) begin fails++; $display("FAIL sh_wen: got pulses %0d at %0d expected 1 at 2", wpulses, wat); end
        checks++; if (mem[4] !== 32'h1234BEEF) begin fails++; $display("FAIL sh_mem: got %h expected 1234beef", mem[4]); end
        mem[8] = 32'h11223344;
        drive_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF5A);
        checks++; if (mem[8] !== 32'h11225A44 || waddr !== 16'd8) begin fails++; $display("FAIL sb_mem: got %h @%h expected 11225a44 @0008", mem[8], waddr); end
        checks++; if (resp_data !== last_load) begin fails++; $display("FAIL store_keeps_data: got %h expected %h", resp_data, last_load); end
    endtask

    task automatic test_misalign;
        drive_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (lat !== 1 || rfault !== 1'b1) begin fails++; $display("FAIL lw_misalign_fault: got lat %0d fault %b expected 1 1", lat, rfault); end
        checks++; if (rdata !== last_load) begin fails++; $display("FAIL lw_misalign_data: got %h expected %h", rdata, last_load); end
        drive_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h5555);
        checks++; if (lat !== 1 || rfault !== 1'b1 || wpulses !== 0) begin fails++; $display("FAIL sh_misalign: got lat %0d fault %b pulses %0d expected 1 1 0", lat, rfault, wpulses); end
        checks++; if (mem[4] !== 32'h1234BEEF) begin fails++; $display("FAIL sh_misalign_mem: got %h expected 1234beef", mem[4]); end
`else
        checks++; if (lat !== 2 || rfault !== 1'b0) begin fails++; $display("FAIL lw_misalign_mask: got lat %0d fault %b expected 2 0", lat, rfault); end
        checks++; if (rdata !== 32'h1234BEEF) begin fails++; $display("FAIL lw_misalign_data: got %h expected 1234beef", rdata); end
        drive_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
        checks++; if (rdata !== 32'h00001234 || rfault !== 1'b0) begin fails++; $display("FAIL lh_misalign_mask: got %h fault %b expected 00001234 0", rdata, rfault); end
`endif
    endtask

    task automatic test_reset_mid_write;
        int seen;
        @(negedge clk);
        req_store = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h30; req_wdata = 32'h77;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 6 && seen == 0; i++) begin
            @(negedge clk);
            if (mem_write_en) seen = 1;
        end
        checks++; if (seen !== 1) begin fails++; $display("FAIL rst_mid_reach_write: got %0d expected 1", seen); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (mem_write_en !== 1'b0 || resp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_drop: got wen %b resp %b expected 0 0", mem_write_en, resp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_idle: got ready %b resp %b expected 1 0", req_ready, resp_valid); end
    endtask

    task automatic test_back_to_back;
        int acc [2];
        int na, nresp;
        logic drop;
        na = 0; nresp = 0; drop = 1'b0;
        @(negedge clk);
        req_store = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10;
        req_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            if (resp_valid) nresp++;
            if (req_valid && req_ready) begin
                if (na < 2) acc[na] = c;
                na++;
                if (na == 2) drop = 1'b1;
            end
            @(posedge clk);
            #1 if (drop) req_valid = 1'b0;
        end
        checks++; if (na !== 2 || acc[1] - acc[0] !== 3) begin fails++; $display("FAIL b2b_spacing: got %0d accepts gap %0d expected 2 gap 3", na, acc[1] - acc[0]); end
        checks++; if (nresp !== 2) begin fails++; $display("FAIL b2b_resp_count: got %0d expected 2", nresp); end
        checks++; if (resp_data !== mem[4]) begin fails++; $display("FAIL b2b_data: got %h expected %h", resp_data, mem[4]); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_load();
        test_subword_store();
        test_misalign();
        test_reset_mid_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
